// File: rtl/qos_csr_bank_pkg.sv
// Shared address map and register field offsets for the QoS CSR bank.
// Pure constants; no logic, no timing, no flow control.
package qos_csr_pkg;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_PRIO     = 8'h01;
    localparam logic [7:0] ADDR_TIMER    = 8'h02;
    localparam logic [7:0] ADDR_STATUS   = 8'h03;
    localparam logic [7:0] ADDR_EVENT    = 8'h04;
    localparam logic [7:0] ADDR_ERR_BASE = 8'h10;

    localparam int CTRL_FALLBACK = 0;
    localparam int CTRL_MANUAL   = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_MCH_LSB  = 8;
    // The whole byte is range-checked so an out-of-range channel is never aliased.
    localparam int CTRL_MCH_W    = 8;

    localparam int STATUS_SP_LSB  = 8;
    localparam int EVENT_CHSW_BIT = 16;

endpackage

// File: rtl/qos_csr_bank_if.sv
// Host register bus: single-cycle write/read strobes, read data one cycle later.
// No backpressure: every strobe is accepted the cycle it is presented.
interface qos_csr_bank_if #(
    parameter int ADDR_W = 8
);
    logic              mm_write_en;
    logic              mm_read_en;
    logic [ADDR_W-1:0] mm_addr;
    logic [31:0]       mm_wdata;
    logic [31:0]       mm_rdata;
    logic              mm_rvalid;

    modport master (
        output mm_write_en, mm_read_en, mm_addr, mm_wdata,
        input  mm_rdata, mm_rvalid
    );

    modport slave (
        input  mm_write_en, mm_read_en, mm_addr, mm_wdata,
        output mm_rdata, mm_rvalid
    );
endinterface

// File: rtl/qos_csr_bank_err_counter.sv
// Saturating error event counter; clear and increment together leave it at 1.
// Updates on the same edge as its inputs; no backpressure.
module qos_err_counter #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [ERR_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? ERR_W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qos_csr_bank.sv
// qos_csr_bank: host CSR bank for the QoS core (config, live status, W1C events, error counters).
// Writes land on the strobe edge, read data one cycle after mm_read_en; no backpressure.
module qos_csr_bank
    import qos_csr_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    localparam int CH_W    = $clog2(NUM_CH),
    parameter  int ERR_W   = 8,
    parameter  int TIMER_W = 20,
    parameter  int ADDR_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    qos_csr_bank_if.slave          mm,
    output logic                   fallback_enable,
    output logic                   manual_enable,
    output logic [CH_W-1:0]        manual_channel,
    output logic [NUM_CH*CH_W-1:0] channel_priority,
    output logic [TIMER_W-1:0]     reset_timer,
    output logic                   valid_config,
    output logic                   irq,
    input  logic [CH_W-1:0]        active_channel,
    input  logic [NUM_CH-1:0]      signal_present,
    input  logic [NUM_CH-1:0]      err_pulse
);

    localparam int PRIO_W = NUM_CH * CH_W;

    logic                  wr_ctrl, wr_prio, wr_timer, wr_event;
    logic [CTRL_MCH_W-1:0] mch_field;
    logic                  irq_en;
    logic [NUM_CH-1:0]     sp_prev, ev_fell, ev_flags, err_clr;
    logic [CH_W-1:0]       ac_prev;
    logic                  ev_chsw;
    logic [ERR_W-1:0]      err_cnt [NUM_CH];
    logic [31:0]           rd_mux, rdata_q;
    logic                  rvalid_q;
    logic                  unused_wdata;

    assign wr_ctrl   = mm.mm_write_en && (mm.mm_addr == ADDR_W'(ADDR_CTRL));
    assign wr_prio   = mm.mm_write_en && (mm.mm_addr == ADDR_W'(ADDR_PRIO));
    assign wr_timer  = mm.mm_write_en && (mm.mm_addr == ADDR_W'(ADDR_TIMER));
    assign wr_event  = mm.mm_write_en && (mm.mm_addr == ADDR_W'(ADDR_EVENT));
    assign mch_field = mm.mm_wdata[CTRL_MCH_LSB +: CTRL_MCH_W];
    assign ev_fell   = sp_prev & ~signal_present;
    assign unused_wdata = ^mm.mm_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fallback_enable  <= 1'b0;
            manual_enable    <= 1'b0;
            irq_en           <= 1'b0;
            manual_channel   <= '0;
            channel_priority <= '0;
            reset_timer      <= '0;
            valid_config     <= 1'b0;
        end else begin
            valid_config <= wr_ctrl | wr_prio | wr_timer;
            if (wr_ctrl) begin
                fallback_enable <= mm.mm_wdata[CTRL_FALLBACK];
                manual_enable   <= mm.mm_wdata[CTRL_MANUAL];
                irq_en          <= mm.mm_wdata[CTRL_IRQ_EN];
                if (mch_field < CTRL_MCH_W'(NUM_CH)) begin
                    manual_channel <= mch_field[CH_W-1:0];
                end
            end
            if (wr_prio) begin
                channel_priority <= mm.mm_wdata[PRIO_W-1:0];
            end
            if (wr_timer) begin
                reset_timer <= mm.mm_wdata[TIMER_W-1:0];
            end
        end
    end

    // A new edge in the same cycle as its clear wins, so no event is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_prev  <= '0;
            ac_prev  <= '0;
            ev_flags <= '0;
            ev_chsw  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            sp_prev  <= signal_present;
            ac_prev  <= active_channel;
            ev_flags <= (ev_flags & ~(wr_event ? mm.mm_wdata[NUM_CH-1:0] : '0)) | ev_fell;
            ev_chsw  <= (ev_chsw & ~(wr_event & mm.mm_wdata[EVENT_CHSW_BIT]))
                        | (ac_prev != active_channel);
            irq      <= irq_en & ((|ev_flags) | ev_chsw);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_err
        assign err_clr[i] = mm.mm_write_en
                            && (mm.mm_addr == ADDR_W'(ADDR_ERR_BASE + 8'(i)));
        qos_err_counter #(.ERR_W(ERR_W)) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (err_pulse[i]),
            .clr  (err_clr[i]),
            .cnt  (err_cnt[i])
        );
    end

    // Read mux sees pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0;
        if (mm.mm_addr == ADDR_W'(ADDR_CTRL)) begin
            rd_mux[CTRL_FALLBACK]           = fallback_enable;
            rd_mux[CTRL_MANUAL]             = manual_enable;
            rd_mux[CTRL_IRQ_EN]             = irq_en;
            rd_mux[CTRL_MCH_LSB +: CH_W]    = manual_channel;
        end else if (mm.mm_addr == ADDR_W'(ADDR_PRIO)) begin
            rd_mux[PRIO_W-1:0]              = channel_priority;
        end else if (mm.mm_addr == ADDR_W'(ADDR_TIMER)) begin
            rd_mux[TIMER_W-1:0]             = reset_timer;
        end else if (mm.mm_addr == ADDR_W'(ADDR_STATUS)) begin
            rd_mux[CH_W-1:0]                = active_channel;
            rd_mux[STATUS_SP_LSB +: NUM_CH] = signal_present;
        end else if (mm.mm_addr == ADDR_W'(ADDR_EVENT)) begin
            rd_mux[NUM_CH-1:0]              = ev_flags;
            rd_mux[EVENT_CHSW_BIT]          = ev_chsw;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (mm.mm_addr == ADDR_W'(ADDR_ERR_BASE + 8'(i))) begin
                rd_mux = 32'(err_cnt[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= mm.mm_read_en;
            if (mm.mm_read_en) begin
                rdata_q <= rd_mux;
            end
        end
    end

    assign mm.mm_rdata  = rdata_q;
    assign mm.mm_rvalid = rvalid_q;

endmodule

// File: tb/tb_qos_csr_bank.sv
// Bench for qos_csr_bank: directed and randomized traffic against a register-level model.
module tb_qos_csr_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qos_csr_bank_if #(.ADDR_W(8)) m4 ();
    qos_csr_bank_if #(.ADDR_W(8)) m8 ();

    logic        fb4, man4, vc4, irq4;
    logic [1:0]  mch4, ac;
    logic [7:0]  prio4;
    logic [19:0] tmr4;
    logic [3:0]  sp, ep;

    logic        fb8, man8, vc8, irq8;
    logic [2:0]  mch8, ac8;
    logic [23:0] prio8;
    logic [19:0] tmr8;
    logic [7:0]  sp8, ep8;

    qos_csr_bank #(.NUM_CH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mm(m4),
        .fallback_enable(fb4), .manual_enable(man4), .manual_channel(mch4),
        .channel_priority(prio4), .reset_timer(tmr4), .valid_config(vc4), .irq(irq4),
        .active_channel(ac), .signal_present(sp), .err_pulse(ep)
    );

    qos_csr_bank #(.NUM_CH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .mm(m8),
        .fallback_enable(fb8), .manual_enable(man8), .manual_channel(mch8),
        .channel_priority(prio8), .reset_timer(tmr8), .valid_config(vc8), .irq(irq8),
        .active_channel(ac8), .signal_present(sp8), .err_pulse(ep8)
    );

    int errors = 0;
    int checks = 0;

    // Register-level view of the 4-channel bank.
    logic [31:0] m_fb, m_man, m_irqen, m_mch, m_prio, m_tmr, m_ev;
    int          m_err [4];

    function automatic void model_reset();
        m_fb = 0; m_man = 0; m_irqen = 0; m_mch = 0; m_prio = 0; m_tmr = 0; m_ev = 0;
        for (int i = 0; i < 4; i++) m_err[i] = 0;
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [31:0] d);
        case (a)
            8'h00: begin
                m_fb = {31'b0, d[0]}; m_man = {31'b0, d[1]}; m_irqen = {31'b0, d[2]};
                if (d[15:8] < 8'd4) m_mch = {24'b0, d[15:8]};
            end
            8'h01: m_prio = d & 32'hFF;
            8'h02: m_tmr  = d & 32'hF_FFFF;
            8'h04: m_ev   = m_ev & ~(d & 32'h1_000F);
            8'h10, 8'h11, 8'h12, 8'h13: m_err[int'(a) - 16] = 0;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h00: return m_fb | (m_man << 1) | (m_irqen << 2) | (m_mch << 8);
            8'h01: return m_prio;
            8'h02: return m_tmr;
            8'h03: return {22'b0, sp, 4'b0, 2'b0, ac};
            8'h04: return m_ev;
            8'h10, 8'h11, 8'h12, 8'h13: return 32'(m_err[int'(a) - 16]);
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        m4.mm_write_en = 1'b1; m4.mm_addr = a; m4.mm_wdata = d;
        tick();
        m4.mm_write_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic v);
        m4.mm_read_en = 1'b1; m4.mm_addr = a;
        tick();
        m4.mm_read_en = 1'b0;
        d = m4.mm_rdata;
        v = m4.mm_rvalid;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({m4.mm_rdata, m4.mm_rvalid} !== 33'h0) begin errors++;
            $display("FAIL reset_bus rdata=%h rvalid=%b want 0", m4.mm_rdata, m4.mm_rvalid); end
        checks++; if ({vc4, irq4, fb4, man4} !== 4'h0) begin errors++;
            $display("FAIL reset_pulses vc=%b irq=%b fb=%b man=%b want 0", vc4, irq4, fb4, man4); end
        checks++; if ({mch4, prio4, tmr4} !== 30'h0) begin errors++;
            $display("FAIL reset_cfg mch=%h prio=%h tmr=%h want 0", mch4, prio4, tmr4); end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ctrl();
        logic [31:0] d; logic v;
        wr(8'h00, 32'h0000_0207); model_write(8'h00, 32'h0000_0207);
        checks++; if ({vc4, fb4, man4, mch4} !== 5'b1_1_1_10) begin errors++;
            $display("FAIL ctrl_first vc=%b fb=%b man=%b mch=%0d want 1,1,1,2", vc4, fb4, man4, mch4); end
        tick();
        checks++; if (vc4 !== 1'b0) begin errors++;
            $display("FAIL ctrl_vc_single vc=%b want 0", vc4); end
        rd(8'h00, d, v);
        checks++; if (v !== 1'b1 || d !== model_read(8'h00)) begin errors++;
            $display("FAIL ctrl_read got=%h v=%b want %h", d, v, model_read(8'h00)); end
        wr(8'h00, 32'h0000_0503); model_write(8'h00, 32'h0000_0503);
        checks++; if (mch4 !== 2'd2 || vc4 !== 1'b1) begin errors++;
            $display("FAIL ctrl_mch_keep mch=%0d vc=%b want 2,1", mch4, vc4); end
        rd(8'h00, d, v);
        checks++; if (d !== 32'h0000_0203) begin errors++;
            $display("FAIL ctrl_irq_en_off got=%h want 00000203", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic v;
        m4.mm_write_en = 1'b1; m4.mm_addr = 8'h01; m4.mm_wdata = 32'h0000_005A;
        tick();
        checks++; if (vc4 !== 1'b1 || prio4 !== 8'h5A) begin errors++;
            $display("FAIL b2b_prio vc=%b prio=%h want 1,5a", vc4, prio4); end
        m4.mm_addr = 8'h02; m4.mm_wdata = 32'h000A_BCDE;
        tick();
        m4.mm_write_en = 1'b0;
        model_write(8'h01, 32'h5A); model_write(8'h02, 32'h000A_BCDE);
        checks++; if (vc4 !== 1'b1 || tmr4 !== 20'hABCDE) begin errors++;
            $display("FAIL b2b_timer vc=%b tmr=%h want 1,abcde", vc4, tmr4); end
        tick();
        checks++; if (vc4 !== 1'b0) begin errors++; $display("FAIL b2b_vc_end vc=%b want 0", vc4); end
        rd(8'h02, d, v);
        checks++; if (v !== 1'b1 || d !== 32'h000A_BCDE) begin errors++;
            $display("FAIL rd_latency got=%h v=%b want 000abcde,1", d, v); end
        tick();
        checks++; if (m4.mm_rvalid !== 1'b0 || m4.mm_rdata !== 32'h000A_BCDE) begin errors++;
            $display("FAIL rd_hold rvalid=%b rdata=%h want 0,000abcde", m4.mm_rvalid, m4.mm_rdata); end
        rd(8'h7F, d, v);
        checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++;
            $display("FAIL rd_unmapped got=%h v=%b want 0,1", d, v); end
        m4.mm_read_en = 1'b1; m4.mm_write_en = 1'b1; m4.mm_addr = 8'h02; m4.mm_wdata = 32'h0001_2345;
        tick();
        m4.mm_read_en = 1'b0; m4.mm_write_en = 1'b0;
        checks++; if (m4.mm_rdata !== 32'h000A_BCDE) begin errors++;
            $display("FAIL rw_same_cycle got=%h want 000abcde", m4.mm_rdata); end
        model_write(8'h02, 32'h0001_2345);
        rd(8'h02, d, v);
        checks++; if (d !== model_read(8'h02)) begin errors++;
            $display("FAIL rw_after got=%h want %h", d, model_read(8'h02)); end
    endtask

    task automatic test_random_cfg();
        logic [7:0]  addrs [7] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h20, 8'h05};
        logic [7:0]  a, ra;
        logic [31:0] d;
        logic v;
        for (int i = 0; i < 24; i++) begin
            a = addrs[$urandom_range(0, 6)];
            d = $urandom;
            if (i % 3 == 0) d[15:8] = 8'($urandom_range(0, 5));
            sp = 4'($urandom); ac = 2'($urandom);
            wr(a, d); model_write(a, d);
            ra = addrs[$urandom_range(0, 6)];
            rd(ra, d, v);
            checks++; if (v !== 1'b1 || d !== model_read(ra)) begin errors++;
                $display("FAIL rand_cfg addr=%h got=%h v=%b want %h", ra, d, v, model_read(ra)); end
        end
        sp = 4'h0; ac = 2'd0;
        tick();
        wr(8'h04, 32'h1_000F); model_write(8'h04, 32'h1_000F);
    endtask

    task automatic test_saturation();
        logic [31:0] d; logic v;
        ep = 4'b0010;
        repeat (300) tick();
        ep = 4'b0000;
        m_err[1] = 255;
        rd(8'h11, d, v);
        checks++; if (d !== 32'h0000_00FF) begin errors++;
            $display("FAIL err_saturate got=%h want 000000ff", d); end
        rd(8'h10, d, v);
        checks++; if (d !== 32'(m_err[0])) begin errors++;
            $display("FAIL err_other_ch got=%h want %h", d, 32'(m_err[0])); end
        m4.mm_write_en = 1'b1; m4.mm_addr = 8'h11; m4.mm_wdata = 32'h0; ep = 4'b0010;
        tick();
        m4.mm_write_en = 1'b0; ep = 4'b0000;
        m_err[1] = 1;
        rd(8'h11, d, v);
        checks++; if (d !== 32'h1) begin errors++;
            $display("FAIL err_clr_inc got=%h want 1", d); end
    endtask

    task automatic test_err_random();
        logic [31:0] d; logic v;
        int c;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ep = 4'($urandom) | 4'($urandom);
            c = -1;
            if ($urandom_range(0, 15) == 0) begin
                c = $urandom_range(0, 3);
                m4.mm_write_en = 1'b1; m4.mm_addr = 8'(16 + c); m4.mm_wdata = $urandom;
            end
            for (int i = 0; i < 4; i++) begin
                if (i == c) m_err[i] = ep[i] ? 1 : 0;
                else if (ep[i]) m_err[i] = (m_err[i] >= 255) ? 255 : m_err[i] + 1;
            end
            tick();
            m4.mm_write_en = 1'b0;
        end
        ep = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            rd(8'(16 + i), d, v);
            checks++; if (d !== 32'(m_err[i])) begin errors++;
                $display("FAIL err_rand ch=%0d got=%h want %h", i, d, 32'(m_err[i])); end
        end
    endtask

    task automatic test_events();
        logic [31:0] d; logic v;
        wr(8'h00, 32'h4); model_write(8'h00, 32'h4);
        sp = 4'hF;
        tick(); tick();
        rd(8'h04, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ev_rise_none got=%h want 0", d); end
        sp = 4'hB;
        tick();
        checks++; if (irq4 !== 1'b0) begin errors++; $display("FAIL irq_early irq=%b want 0", irq4); end
        tick();
        checks++; if (irq4 !== 1'b1) begin errors++; $display("FAIL irq_assert irq=%b want 1", irq4); end
        m_ev = m_ev | 32'h4;
        rd(8'h04, d, v);
        checks++; if (d !== m_ev) begin errors++; $display("FAIL ev_fall got=%h want %h", d, m_ev); end
        sp = 4'hF;
        tick();
        sp = 4'hB; wr(8'h04, 32'h4);
        m_ev = (m_ev & ~32'h4) | 32'h4;
        rd(8'h04, d, v);
        checks++; if (d !== m_ev || irq4 !== 1'b1) begin errors++;
            $display("FAIL ev_set_wins got=%h irq=%b want %h,1", d, irq4, m_ev); end
        wr(8'h04, 32'h4); model_write(8'h04, 32'h4);
        tick();
        checks++; if (irq4 !== 1'b0) begin errors++; $display("FAIL irq_clear irq=%b want 0", irq4); end
        ac = 2'd3;
        tick(); tick();
        m_ev = m_ev | 32'h1_0000;
        rd(8'h04, d, v);
        checks++; if (d !== m_ev || irq4 !== 1'b1) begin errors++;
            $display("FAIL ev_chsw got=%h irq=%b want %h,1", d, irq4, m_ev); end
        rd(8'h03, d, v);
        checks++; if (d !== model_read(8'h03)) begin errors++;
            $display("FAIL status got=%h want %h", d, model_read(8'h03)); end
        wr(8'h04, 32'h1_0000); model_write(8'h04, 32'h1_0000);
    endtask

    task automatic test_event_random();
        logic [31:0] d, mask; logic v;
        logic [3:0] psp; logic [1:0] pac;
        for (int cyc = 0; cyc < 80; cyc++) begin
            psp = sp; pac = ac;
            sp = 4'($urandom);
            if ($urandom_range(0, 3) == 0) ac = 2'($urandom);
            mask = 32'h0;
            if ($urandom_range(0, 2) == 0) begin
                mask = $urandom;
                m4.mm_write_en = 1'b1; m4.mm_addr = 8'h04; m4.mm_wdata = mask;
            end
            m_ev = (m_ev & ~(mask & 32'h1_000F)) | {28'b0, psp & ~sp} | ((ac != pac) ? 32'h1_0000 : 32'h0);
            tick();
            m4.mm_write_en = 1'b0;
        end
        rd(8'h04, d, v);
        checks++; if (d !== m_ev) begin errors++; $display("FAIL ev_rand got=%h want %h", d, m_ev); end
        checks++; if (irq4 !== (m_ev != 0)) begin errors++;
            $display("FAIL irq_rand irq=%b want %b", irq4, m_ev != 0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic v;
        m4.mm_read_en = 1'b1; m4.mm_addr = 8'h02;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        m4.mm_read_en = 1'b0;
        checks++; if (m4.mm_rvalid !== 1'b0 || m4.mm_rdata !== 32'h0) begin errors++;
            $display("FAIL rst_mid_read rvalid=%b rdata=%h want 0,0", m4.mm_rvalid, m4.mm_rdata); end
        checks++; if ({vc4, irq4, fb4, man4, mch4, prio4, tmr4} !== 34'h0) begin errors++;
            $display("FAIL rst_mid_outs irq=%b fb=%b prio=%h tmr=%h want 0", irq4, fb4, prio4, tmr4); end
        sp = 4'h0; ac = 2'd0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        model_reset();
        rd(8'h11, d, v);
        checks++; if (d !== 32'(m_err[1])) begin errors++; $display("FAIL rst_mid_err got=%h want 0", d); end
        rd(8'h04, d, v);
        checks++; if (d !== m_ev) begin errors++; $display("FAIL rst_mid_ev got=%h want 0", d); end
    endtask

    task automatic test_scaling();
        m8.mm_write_en = 1'b1; m8.mm_addr = 8'h01; m8.mm_wdata = 32'h00FA_C688;
        tick();
        m8.mm_write_en = 1'b0;
        checks++; if (prio8 !== 24'hFAC688 || vc8 !== 1'b1) begin errors++;
            $display("FAIL ch8_prio prio=%h vc=%b want fac688,1", prio8, vc8); end
        m8.mm_read_en = 1'b1;
        tick();
        m8.mm_read_en = 1'b0;
        checks++; if (m8.mm_rdata !== 32'h00FA_C688 || m8.mm_rvalid !== 1'b1) begin errors++;
            $display("FAIL ch8_prio_rd got=%h v=%b want 00fac688,1", m8.mm_rdata, m8.mm_rvalid); end
        m8.mm_write_en = 1'b1; m8.mm_addr = 8'h00; m8.mm_wdata = 32'h0000_0507;
        tick();
        m8.mm_wdata = 32'h0000_0903;
        tick();
        m8.mm_write_en = 1'b0;
        checks++; if (mch8 !== 3'd5 || fb8 !== 1'b1 || man8 !== 1'b1) begin errors++;
            $display("FAIL ch8_mch mch=%0d fb=%b man=%b want 5,1,1", mch8, fb8, man8); end
    endtask

    initial begin
        m4.mm_write_en = 1'b0; m4.mm_read_en = 1'b0; m4.mm_addr = '0; m4.mm_wdata = '0;
        m8.mm_write_en = 1'b0; m8.mm_read_en = 1'b0; m8.mm_addr = '0; m8.mm_wdata = '0;
        ac = '0; sp = '0; ep = '0; ac8 = '0; sp8 = '0; ep8 = '0;
        model_reset();
        test_reset();
        test_ctrl();
        test_back_to_back();
        test_random_cfg();
        test_saturation();
        test_err_random();
        test_events();
        test_event_random();
        test_reset_mid();
        test_scaling();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
